// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// controller states and the alignment/legality check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {CLEAR, READY} mem_state_t;

  // True when funct3 names a defined access size and offset is aligned for it.
  function automatic logic size_ok(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B, F3_BU: size_ok = 1'b1;
      F3_H, F3_HU: size_ok = ~offset[0];
      F3_W:        size_ok = (offset == 2'b00);
      default:     size_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with four independently writable byte lanes and a
// registered read port. The array itself carries no reset.
module byte_lane_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] lane_q;

    // Read returns the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
      if (we[gi]) mem[waddr] <= wdata[8*gi +: 8];
      lane_q <= mem[raddr];
    end

    assign rdata[8*gi +: 8] = lane_q;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte/halfword/word loads and stores on a 512-byte
// RAM, with a zeroing sweep after reset and misalignment reporting.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 9,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              misaligned,
  output logic              busy
);

  localparam int DEPTH = (2 ** ADDR_W) / 4;
  localparam int IDX_W = ADDR_W - 2;
  localparam mem_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  mem_state_t       state_reg, state_next;
  logic [IDX_W-1:0] clr_idx_reg, clr_idx_next;

  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        offset;
  logic              legal, active, do_store, do_load, drop;
  logic [3:0]        lane_mask;
  logic [DATA_W-1:0] lane_data;

  logic [3:0]        ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              rd_valid_reg, misaligned_reg;
  logic [2:0]        f3_reg;
  logic [1:0]        off_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] load_ext;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  // Request decode; a store wins over a simultaneous load.
  always_comb begin
    word_idx = addr[ADDR_W-1:2];
    offset   = addr[1:0];
    legal    = size_ok(funct3, offset);
    active   = (state_reg == READY);
    do_store = active && wr && legal;
    do_load  = active && rd && !wr && legal;
    drop     = active && (wr || rd) && !legal;
    case (funct3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << offset;
        lane_data = {4{wr_data[7:0]}};
      end
      2'b01: begin
        lane_mask = 4'b0011 << offset;
        lane_data = {2{wr_data[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = wr_data;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= RESET_STATE;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    ram_we       = 4'b0000;
    ram_waddr    = word_idx;
    ram_wdata    = lane_data;
    case (state_reg)
      CLEAR: begin
        ram_we       = 4'b1111;
        ram_waddr    = clr_idx_reg;
        ram_wdata    = '0;
        clr_idx_next = clr_idx_reg + IDX_W'(1);
        if (clr_idx_reg == IDX_W'(DEPTH - 1)) state_next = READY;
      end
      READY: begin
        if (do_store) ram_we = lane_mask;
      end
    endcase
  end

  byte_lane_ram #(
    .DEPTH(DEPTH),
    .AW   (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(word_idx),
    .rdata(ram_rdata)
  );

  // Lane select and extension use the size/offset captured with the load.
  always_comb begin
    sel_byte = ram_rdata[{off_reg, 3'b000} +: 8];
    sel_half = off_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (f3_reg)
      F3_B:    load_ext = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_ext = {24'b0, sel_byte};
      F3_H:    load_ext = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_ext = {16'b0, sel_half};
      default: load_ext = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_reg   <= 1'b0;
      misaligned_reg <= 1'b0;
      f3_reg         <= F3_W;
      off_reg        <= 2'b00;
      hold_reg       <= '0;
    end else begin
      rd_valid_reg   <= do_load;
      misaligned_reg <= drop;
      if (do_load) begin
        f3_reg  <= funct3;
        off_reg <= offset;
      end
      if (rd_valid_reg) hold_reg <= load_ext;
    end
  end

  // rd_data shows the fresh result during the valid cycle, then holds it.
  assign rd_data    = rd_valid_reg ? load_ext : hold_reg;
  assign rd_valid   = rd_valid_reg;
  assign misaligned = misaligned_reg;
  assign busy       = (state_reg == CLEAR);

endmodule
